// File: rtl/vec_pkg.sv
// Shared types and default geometry for the vector load collector.
package vec_pkg;

  localparam int VEC_W  = 128;
  localparam int WORD_W = 32;
  localparam int LANES  = VEC_W / WORD_W;
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_e;

  typedef logic [VEC_W-1:0]  vec_t;
  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/lane_acc.sv
// V-bit beat accumulator: synchronous clear plus one lane-indexed N-bit write port.
// acc_nxt_o exposes the value being written this cycle so the owner can
// capture a result that includes the final beat without an extra cycle.
module lane_acc
  import vec_pkg::*;
#(
  parameter int V  = 128,
  parameter int N  = 32,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [IW-1:0] idx_i,
  input  logic [N-1:0]  data_i,
  output logic [V-1:0]  acc_nxt_o
);

  logic [V-1:0] acc_q, acc_d;

  // Clear wins over a write; otherwise drop the word into its lane slot.
  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (we_i)
      acc_d[idx_i*N +: N] = data_i;
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/vector_load_collector.sv
// Gathers memory beats into a vector (or a single scalar word) and issues a
// one-cycle register-file write-back once the last beat lands.
module vector_load_collector
  import vec_pkg::*;
#(
  parameter int V = 128,
  parameter int N = 32,
  parameter int R = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  is_vector,
  input  logic [R-1:0]                          rd_in,
  input  logic                                  beat_valid,
  input  logic [N-1:0]                          beat_data,
  input  logic                                  flush,
  output logic                                  busy,
  output logic [((V/N) > 1 ? $clog2(V/N) : 1)-1:0] lane_idx,
  output logic                                  wb_vec_en,
  output logic                                  wb_scl_en,
  output logic [R-1:0]                          wb_addr,
  output logic [V-1:0]                          wb_vdata,
  output logic [N-1:0]                          wb_sdata,
  output logic                                  done
);

  localparam int NLANES = V / N;
  localparam int IW     = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [IW-1:0] LAST_LANE = IW'(NLANES - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] lane_q, lane_d;
  logic          is_vec_q;
  logic [R-1:0]  rd_q;

  logic          accept;    // latch a new load this cycle
  logic          acc_we;
  logic          enter_wr;  // final beat captured, WRITE next cycle
  logic          last_beat;
  logic [V-1:0]  acc_nxt;

  logic          wb_vec_en_q, wb_scl_en_q, done_q;
  logic [R-1:0]  wb_addr_q;
  logic [V-1:0]  wb_vdata_q;
  logic [N-1:0]  wb_sdata_q;

  assign last_beat = is_vec_q ? (lane_q == LAST_LANE) : (lane_q == '0);

  // Next-state and control decode; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    accept   = 1'b0;
    acc_we   = 1'b0;
    enter_wr = 1'b0;
    if (flush) begin
      state_d = IDLE;
      lane_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            accept  = 1'b1;
            lane_d  = '0;
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (beat_valid) begin
            acc_we = 1'b1;
            if (last_beat) begin
              enter_wr = 1'b1;
              lane_d   = '0;
              state_d  = WRITE;
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end
        end
        WRITE: begin
          state_d = IDLE;
          // Back-to-back loads: accept the next start without an idle bubble.
          if (start) begin
            accept  = 1'b1;
            lane_d  = '0;
            state_d = COLLECT;
          end
        end
        default: begin
          state_d = IDLE;
          lane_d  = '0;
        end
      endcase
    end
  end

  // FSM state, lane pointer and the latched load descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      is_vec_q <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (accept) begin
        is_vec_q <= is_vector;
        rd_q     <= rd_in;
      end
    end
  end

  lane_acc #(.V(V), .N(N), .IW(IW)) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (accept),
    .we_i      (acc_we),
    .idx_i     (lane_q),
    .data_i    (beat_data),
    .acc_nxt_o (acc_nxt)
  );

  // Write-back registers: strobes live only in WRITE, data holds until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_vec_en_q <= 1'b0;
      wb_scl_en_q <= 1'b0;
      done_q      <= 1'b0;
      wb_addr_q   <= '0;
      wb_vdata_q  <= '0;
      wb_sdata_q  <= '0;
    end else begin
      wb_vec_en_q <= enter_wr & is_vec_q;
      wb_scl_en_q <= enter_wr & ~is_vec_q;
      done_q      <= enter_wr;
      if (enter_wr) begin
        wb_addr_q <= rd_q;
        if (is_vec_q) wb_vdata_q <= acc_nxt;
        else          wb_sdata_q <= acc_nxt[N-1:0];
      end
    end
  end

  // Stall starts in the same cycle as the start pulse.
  assign busy      = (state_q != IDLE) | start;
  assign lane_idx  = lane_q;
  assign wb_vec_en = wb_vec_en_q;
  assign wb_scl_en = wb_scl_en_q;
  assign done      = done_q;
  assign wb_addr   = wb_addr_q;
  assign wb_vdata  = wb_vdata_q;
  assign wb_sdata  = wb_sdata_q;

endmodule

// File: tb/tb_vector_load_collector.sv
// Directed bench with a write-back scoreboard for vector_load_collector.
module tb_vector_load_collector;

  logic         clk, rst, start, is_vector, beat_valid, flush;
  logic [3:0]   rd_in;
  logic [31:0]  beat_data;
  logic         busy, wb_vec_en, wb_scl_en, done;
  logic [1:0]   lane_idx;
  logic [3:0]   wb_addr;
  logic [127:0] wb_vdata;
  logic [31:0]  wb_sdata;

  vector_load_collector #(.V(128), .N(32), .R(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_vector(is_vector), .rd_in(rd_in),
    .beat_valid(beat_valid), .beat_data(beat_data), .flush(flush),
    .busy(busy), .lane_idx(lane_idx), .wb_vec_en(wb_vec_en), .wb_scl_en(wb_scl_en),
    .wb_addr(wb_addr), .wb_vdata(wb_vdata), .wb_sdata(wb_sdata), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         vec;
    logic [3:0]   addr;
    logic [127:0] vdata;
    logic [31:0]  sdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   n_push = 0;

  logic [31:0]  w1 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0]  w2 [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
  logic [31:0]  w3 [4] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
  logic [127:0] vec1, vec2, vec3;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic [3:0] a, input logic [127:0] vd,
                      input logic [31:0] sd);
    exp_t e;
    e.vec = v; e.addr = a; e.vdata = vd; e.sdata = sd;
    sb.push_back(e);
    n_push++;
  endtask

  // Drive one cycle's inputs just after the edge, then settle before checking.
  task automatic step(input logic s, input logic v, input logic [3:0] r,
                      input logic bv, input logic [31:0] bd, input logic fl);
    @(posedge clk);
    #1;
    start = s; is_vector = v; rd_in = r; beat_valid = bv; beat_data = bd; flush = fl;
    #3;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_lane"},  lane_idx,  0);
    chk({tag, "_ven"},   wb_vec_en, 0);
    chk({tag, "_sen"},   wb_scl_en, 0);
    chk({tag, "_addr"},  wb_addr,   0);
    chk({tag, "_vdata"}, wb_vdata,  0);
    chk({tag, "_sdata"}, wb_sdata,  0);
    chk({tag, "_done"},  done,      0);
  endtask

  // Scoreboard side: every write-back must match the oldest pending load.
  always @(negedge clk) begin
    if (!rst && (done === 1'b1 || wb_vec_en === 1'b1 || wb_scl_en === 1'b1)) begin
      chk("wb_strobe_vs_done", done, 1);
      if (done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_vec_en", wb_vec_en, mon_e.vec);
          chk("sb_scl_en", wb_scl_en, !mon_e.vec);
          chk("sb_addr",   wb_addr,   mon_e.addr);
          if (mon_e.vec) chk("sb_vdata", wb_vdata, mon_e.vdata);
          else           chk("sb_sdata", wb_sdata, mon_e.sdata);
        end
      end
    end
  end

  initial begin
    vec1 = {w1[3], w1[2], w1[1], w1[0]};
    vec2 = {w2[3], w2[2], w2[1], w2[0]};
    vec3 = {w3[3], w3[2], w3[1], w3[0]};
    rst = 1'b1; start = 0; is_vector = 0; rd_in = 0; beat_valid = 0; beat_data = 0; flush = 0;

    // Reset state
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1; rst = 1'b0;

    // Vector load, minimum latency
    push(1'b1, 4'd3, vec1, 32'h0);
    step(1, 1, 4'd3, 0, 32'h0, 0);
    chk("v_busy_c0", busy, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'd0, 1, w1[i], 0);
      chk($sformatf("v_lane_c%0d", i + 1), lane_idx, i);
      chk($sformatf("v_busy_c%0d", i + 1), busy, 1);
    end
    idle();
    chk("v_done_c5", done, 1);
    chk("v_ven_c5",  wb_vec_en, 1);
    chk("v_busy_c5", busy, 1);
    idle();
    chk("v_busy_c6", busy, 0);
    chk("v_done_c6", done, 0);

    // Scalar load; vector data must be left alone
    push(1'b0, 4'd7, 128'h0, 32'hDEADBEEF);
    step(1, 0, 4'd7, 0, 32'h0, 0);
    step(0, 0, 4'd0, 1, 32'hDEADBEEF, 0);
    idle();
    chk("s_sen_c2",   wb_scl_en, 1);
    chk("s_ven_c2",   wb_vec_en, 0);
    chk("s_done_c2",  done, 1);
    chk("s_vhold_c2", wb_vdata, vec1);
    idle();
    chk("s_busy_c3", busy, 0);

    // Gapped beats
    push(1'b1, 4'd3, vec1, 32'h0);
    step(1, 1, 4'd3, 0, 32'h0, 0);
    step(0, 0, 4'd0, 1, w1[0], 0);
    step(0, 0, 4'd0, 1, w1[1], 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("g_lane_hold", lane_idx, 2);
      chk("g_busy_hold", busy, 1);
      chk("g_no_done",   done, 0);
    end
    step(0, 0, 4'd0, 1, w1[2], 0);
    step(0, 0, 4'd0, 1, w1[3], 0);
    idle();
    chk("g_done_c8", done, 1);
    idle();

    // Flush mid-collect, then flush together with start
    step(1, 1, 4'd9, 0, 32'h0, 0);
    step(0, 0, 4'd0, 1, 32'hFFFF0000, 0);
    step(0, 0, 4'd0, 1, 32'hFFFF0001, 0);
    step(0, 0, 4'd0, 0, 32'h0, 1);
    idle();
    chk("f_busy", busy, 0);
    chk("f_lane", lane_idx, 0);
    chk("f_done", done, 0);
    step(1, 1, 4'd9, 0, 32'h0, 1);
    idle();
    chk("fs_busy", busy, 0);
    chk("fs_addr", wb_addr, 3);

    // Reset mid-collect
    step(1, 1, 4'd10, 0, 32'h0, 0);
    step(0, 0, 4'd0, 1, 32'h55555555, 0);
    beat_valid = 0; rst = 1'b1;
    #2;
    chk_all_zero("rst_mid");
    @(posedge clk); #1; rst = 1'b0; #3;
    idle();
    idle();
    chk("rst_after_busy", busy, 0);
    chk("rst_after_done", done, 0);

    // Back-to-back loads
    push(1'b1, 4'd3, vec1, 32'h0);
    step(1, 1, 4'd3, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 1, w1[i], 0);
    push(1'b1, 4'd5, vec2, 32'h0);
    step(1, 1, 4'd5, 0, 32'h0, 0);
    chk("b2b_done1", done, 1);
    chk("b2b_busy",  busy, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'd0, 1, w2[i], 0);
      chk($sformatf("b2b_lane%0d", i), lane_idx, i);
      chk("b2b_no_done", done, 0);
    end
    idle();
    chk("b2b_done2", done, 1);
    idle();

    // Ignored events: beat in IDLE, beat with start, start during COLLECT
    step(0, 0, 4'd0, 1, 32'hBADBAD00, 0);
    chk("ig_idle_lane", lane_idx, 0);
    chk("ig_idle_busy", busy, 0);
    push(1'b1, 4'd12, vec3, 32'h0);
    step(1, 1, 4'd12, 1, 32'hBADBAD01, 0);
    step(1, 0, 4'd4, 1, w3[0], 0);
    chk("ig_start_beat_lane", lane_idx, 0);
    step(0, 0, 4'd0, 1, w3[1], 0);
    chk("ig_collect_start_lane", lane_idx, 1);
    step(0, 0, 4'd0, 1, w3[2], 0);
    step(0, 0, 4'd0, 1, w3[3], 0);
    idle();
    chk("ig_done", done, 1);
    idle();
    idle();
    idle();

    chk("sb_empty", sb.size(), 0);
    chk("done_count", n_done, n_push);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vector_load_collector.md
Name: vector_load_collector

Overview:
- Downstream of the vector load/store unit. Gathers the N-bit words returned by memory, one per beat, into a V-bit vector.
- A scalar load is a single beat.
- Once the last beat arrives, it issues a one-cycle write-back to the vector or scalar register file.
- It holds the CPU stall until the write-back has been issued.

Parameters:
- V, 128, vector width in bits.
- N, 32, scalar/memory word width in bits; LANES = V/N (4 by default).
- R, 4, register-file address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse requesting a new load.
- is_vector  in  1  sampled with start: 1 = vector load (LANES beats), 0 = scalar load (1 beat).
- rd_in  in  R  destination register, sampled with start.
- beat_valid  in  1  beat_data holds a valid memory word this cycle.
- beat_data  in  N  word returned by memory.
- flush  in  1  abort the current load; no write-back.
- busy  out  1  stall request to the CPU.
- lane_idx  out  $clog2(LANES)  index of the lane expected next.
- wb_vec_en  out  1  vector register-file write enable.
- wb_scl_en  out  1  scalar register-file write enable.
- wb_addr  out  R  write-back destination.
- wb_vdata  out  V  assembled vector.
- wb_sdata  out  N  scalar result, equal to lane 0.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state=IDLE; busy, lane_idx, wb_vec_en, wb_scl_en, wb_addr, wb_vdata, wb_sdata, done and the internal mode register are all 0. Reset asserted mid-load discards the load immediately.
- FSM states: IDLE, COLLECT, WRITE.
- IDLE:
  - beat_valid is ignored.
  - On start: latch rd_in and is_vector, clear the accumulator to 0, set lane_idx=0, next state COLLECT.
- COLLECT:
  - On beat_valid: write beat_data into accumulator bits [lane_idx*N +: N] (lane 0 = bits N-1:0), then lane_idx+1.
  - The last beat is lane LANES-1 for a vector load, or lane 0 for a scalar load. On the last beat, next state WRITE and lane_idx returns to 0 (no wrap beyond LANES-1).
  - A cycle without beat_valid holds all state; waiting is unbounded.
  - start is ignored in this state.
- WRITE, exactly one cycle:
  - done=1.
  - Vector load: wb_vec_en=1, wb_vdata=accumulator.
  - Scalar load: wb_scl_en=1, wb_sdata=lane 0, and wb_vdata is not driven from the accumulator.
  - wb_addr=latched rd in both cases.
  - Next state is IDLE. If start is high in this cycle, the new load is accepted (latch, clear, go to COLLECT), giving back-to-back loads with no idle bubble.
  - beat_valid is ignored.
- Output timing:
  - wb_*_en and done are registered and high only in the WRITE cycle.
  - wb_vdata, wb_sdata and wb_addr hold their values until the next WRITE cycle.
- busy: combinational = (state != IDLE) | start, so the CPU stalls in the same cycle as the start pulse.
- A beat arriving in the same cycle as start is not captured; beats count from the cycle after start.
- Minimum latency for a vector load: start at cycle 0, beats at cycles 1-4, WRITE at cycle 5. Scalar load: beat at cycle 1, WRITE at cycle 2.
- flush has the highest priority. In any state it forces IDLE next cycle, suppresses write-back and done, and clears lane_idx. flush together with start: start is ignored.
- Unused upper accumulator lanes stay 0 for scalar loads.

Decomposition:
- Shared package vec_pkg:
  - state enum {IDLE, COLLECT, WRITE};
  - localparam LANES = V/N;
  - lane-index width;
  - typedefs vec_t (V bits) and word_t (N bits).
- Natural sub-module: lane_acc. It holds the V-bit accumulator with clear and a lane-indexed N-bit write port. The FSM and write-back registers stay in the top module.

Test Plan:
- Vector load: start (is_vector=1, rd_in=3), then beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles -> in cycle 5, wb_vec_en=1, done=1, wb_addr=3, wb_vdata=0x44444444_33333333_22222222_11111111. busy is high in cycles 0-5 and low in cycle 6.
- Scalar load: start (is_vector=0, rd_in=7), beat 0xDEADBEEF -> in cycle 2, wb_scl_en=1, wb_sdata=0xDEADBEEF, wb_addr=7, wb_vec_en=0.
- Gapped beats: vector load with beat_valid low for 3 cycles between lanes 1 and 2 -> lane_idx holds at 2, busy stays high, result identical to the first scenario, WRITE arrives 3 cycles later.
- Flush after 2 beats, then reset pulse mid-COLLECT on a second load -> no wb_*_en or done in either case. State is IDLE and lane_idx=0; after reset all outputs are 0.
- Back-to-back: start asserted during the WRITE cycle with rd_in=5 -> the first write-back completes and the second load collects 4 new beats. Its write-back has wb_addr=5, and done pulses only once per load.
- Ignored events: beat_valid in IDLE, start during COLLECT, and a beat in the same cycle as start -> none alter the accumulator, lane_idx or wb_addr.
